bht_predictor: RTL

//  Parametrised tagged branch history table of 2-bit saturating counters; successor to the fixed 16-entry BHT.

---
 rtl/bht_predictor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bht_predictor.sv
// -----------------------------------------------------------------------------
// bht_predictor
//   Tagged branch history table of 2-bit saturating counters.
//   Looks up the branch in ID (combinationally, zero latency) and predicts it
//   taken when the BTB also hits. Trains at EX on resolved conditional
//   branches. Flags mispredictions to the hazard unit / NPC mux. Keeps
//   saturating statistics of branches and mispredicted cycles.
//
//   Optional feature: define BHT_GSHARE_EN to XOR a global history register
//   into the table index (gshare). When the macro is undefined, the index is
//   taken from the PC only.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   IDpc         in   32      PC in ID (lookup and fetched-path check)
//   BTBhit       in   1       BTB holds a target for IDpc
//   EXpc         in   32      PC of the branch in EX (update)
//   BrNPC        in   32      resolved branch target
//   BranchE      in   1       branch in EX is taken
//   BranchTypeE  in   3       nonzero = conditional branch in EX
//   BHThit       out  1       predict taken for IDpc
//   PredictMiss  out  2       00 ok, 10 taken-but-wrong-path,
//                             01 not-taken-but-wrong-path
//   branch_cnt   out  STAT_W  resolved conditional branches (saturating)
//   miss_cnt     out  STAT_W  cycles with PredictMiss != 0 (saturating)
// -----------------------------------------------------------------------------
module bht_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter int         TAG_BITS   = 26,
  parameter logic [1:0] INIT_CNT   = 2'b01,
  parameter int         STAT_W     = 32,
  parameter int         GHR_BITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IDpc,
  input  logic              BTBhit,
  input  logic [31:0]       EXpc,
  input  logic [31:0]       BrNPC,
  input  logic              BranchE,
  input  logic [2:0]        BranchTypeE,
  output logic              BHThit,
  output logic [1:0]        PredictMiss,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic                  update_en;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [TAG_BITS-1:0]   update_tag;

  // Flat views of the table for the read muxes; each entry is written only
  // by its own generate block.
  logic                  valid_arr [ENTRIES];
  logic [TAG_BITS-1:0]   tag_arr   [ENTRIES];
  logic [1:0]            cnt_arr   [ENTRIES];

  assign update_en  = (BranchTypeE != 3'd0);
  assign lookup_tag = IDpc[TAG_HI:TAG_LO];
  assign update_tag = EXpc[TAG_HI:TAG_LO];

`ifdef BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_reg;
  logic [GHR_BITS:0]   ghr_shift;

  // Shift left inserting the resolved direction; the top bit falls off.
  assign ghr_shift = {ghr_reg, BranchE};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (update_en) begin
      ghr_reg <= ghr_shift[GHR_BITS-1:0];
    end
  end

  // Both ports use the pre-edge history, so lookup and update agree within
  // a cycle.
  assign lookup_idx = IDpc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_reg);
  assign update_idx = EXpc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_reg);
`else
  logic [GHR_BITS-1:0] unused_ghr;
  assign unused_ghr = '0;

  assign lookup_idx = IDpc[INDEX_BITS+1:2];
  assign update_idx = EXpc[INDEX_BITS+1:2];
`endif

  // Next counter value for the entry being updated.
  logic       update_hit;
  logic [1:0] update_cur;
  logic [1:0] cnt_next;

  assign update_cur = cnt_arr[update_idx];
  assign update_hit = valid_arr[update_idx] && (tag_arr[update_idx] == update_tag);

  always_comb begin
    cnt_next = INIT_CNT;
    if (!update_hit) begin
      // Fresh allocation: a taken branch starts weakly taken.
      cnt_next = BranchE ? 2'b10 : INIT_CNT;
    end else if (BranchE) begin
      cnt_next = (update_cur == 2'b11) ? 2'b11 : update_cur + 2'd1;
    end else begin
      cnt_next = (update_cur == 2'b00) ? 2'b00 : update_cur - 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : gen_entry
      logic                valid_reg;
      logic [TAG_BITS-1:0] tag_reg;
      logic [1:0]          cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          cnt_reg   <= INIT_CNT;
        end else if (update_en && (update_idx == INDEX_BITS'(gi))) begin
          valid_reg <= 1'b1;
          tag_reg   <= update_tag;
          cnt_reg   <= cnt_next;
        end
      end

      assign valid_arr[gi] = valid_reg;
      assign tag_arr[gi]   = tag_reg;
      assign cnt_arr[gi]   = cnt_reg;
    end
  endgenerate

  // Lookup reads the registered table, so a same-cycle update is only seen
  // on the following cycle. Outputs are forced low while reset is held.
  always_comb begin
    BHThit = 1'b0;
    if (!rst) begin
      BHThit = valid_arr[lookup_idx] && (tag_arr[lookup_idx] == lookup_tag) &&
               cnt_arr[lookup_idx][1] && BTBhit;
    end
  end

  always_comb begin
    PredictMiss = 2'b00;
    if (!rst) begin
      if (BranchE) begin
        PredictMiss = (IDpc == BrNPC) ? 2'b00 : 2'b10;
      end else if (update_en) begin
        PredictMiss = (IDpc == EXpc + 32'd4) ? 2'b00 : 2'b01;
      end
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (update_en && (branch_cnt != {STAT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if ((PredictMiss != 2'b00) && (miss_cnt != {STAT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule
